mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the RV32M ops that the single-cycle ALU does not cover.
//  Sits in EX beside the ALU. Takes operands and func3 when the decoder flags an M-type op
//  (opcode 0110011, func7 = 0000001).
//  Runs a radix-2 iterative shift-add multiply or restoring divide, and stalls IF/ID/EX while busy.
//  Returns one XLEN result with a single-cycle done pulse.
// PARAMETERS
//  XLEN   32  operand/result width; must be >= 2
//  CNT_W  $clog2(XLEN)+1  width of the iteration counter (derived; do not override)
// PORTS
//  clk     in   1     rising-edge clock; the only clock
//  rst_n   in   1     asynchronous active-low reset
//  start   in   1     level; held high by EX while the M-op occupies EX, until done
//  func3   in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1     in   XLEN  operand A / dividend, sampled only on accept
//  rs2     in   XLEN  operand B / divisor, sampled only on accept
//  flush   in   1     branch/exception kill; aborts any op in progress
//  stall   out  1     combinational: start & ~done & ~flush; freezes PC, IF/ID and ID/EX
//  busy    out  1     registered: state is CALC or FIX
//  done    out  1     registered one-cycle pulse; result valid this cycle only
//  result  out  XLEN  registered; holds the last completed value until the next done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, internal regs=0.
//  FSM states: IDLE, CALC, FIX, DONE.
//  IDLE -> accept when start=1 and flush=0:
//   - latch func3 and operands; compute operand signs (MULH/DIV/REM signed both; MULHSU rs1 only).
//   - divide by zero (rs2=0), DIV/DIVU/REM/REMU: go straight to DONE.
//     result = all-ones for DIV/DIVU; result = rs1 for REM/REMU.
//   - signed overflow (DIV/REM, rs1=1<<(XLEN-1), rs2=all-ones): go straight to DONE.
//     result = rs1 for DIV; result = 0 for REM.
//   - otherwise: operate on magnitudes of signed operands, counter=XLEN, go to CALC.
//  CALC: exactly one iteration per cycle, counter decrements by 1; leave when counter reaches 0.
//   - multiply: 2*XLEN-bit product register.
//   - divide: XLEN-bit remainder register, XLEN-bit quotient register.
//  FIX (1 cycle):
//   - negate the product if the operand signs differ.
//   - DIV: negate the quotient if the signs differ. REM: remainder takes the dividend's sign.
//   - select the result: MUL = product[XLEN-1:0]; MULH/MULHSU/MULHU = product[2XLEN-1:XLEN].
//   - register result and go to DONE.
//  DONE: done=1 for this cycle, then IDLE unconditionally.
//   - start being high in DONE is the old instruction; it is not re-accepted.
//  Latency (accept edge -> done cycle):
//   - normal ops: XLEN+2 cycles (34 at XLEN=32).
//   - special divide cases: 1 cycle.
//  Handshake:
//   - start must stay high until done unless flush.
//   - start dropping without flush is illegal; assert it in simulation.
//  flush: in any state, next state=IDLE, done=0, result unchanged. flush in IDLE blocks accept.
//  flush and done in the same cycle: done still pulses; the pipeline discards it.
//  rst_n asserted mid-op: immediate return to reset values; nothing completes.
//  All arithmetic is modulo 2^XLEN except the 2*XLEN product. Negation is two's complement.
// TESTING
//  MUL rs1=7, rs2=0xFFFFFFFD -> done 34 cycles after accept, result=0xFFFFFFEB.
//   Check that stall is high from accept until done.
//  MULH 0x80000000*0x80000000 -> result=0x40000000.
//   MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF*2 -> result=0xFFFFFFFF.
//  DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> result=0xFFFFFFFD.
//   REM with the same operands -> result=0xFFFFFFFF.
//   DIVU 100/7 -> result=14. REMU 100/7 -> result=2.
//  DIVU 5/0 -> done 1 cycle after accept, result=0xFFFFFFFF.
//   REM 5/0 -> result=5.
//   DIV 0x80000000/0xFFFFFFFF -> result=0x80000000. REM with the same operands -> result=0.
//  flush asserted on cycle 10 of CALC -> no done pulse, busy=0 next cycle, result keeps its prior value.
//   A new start then completes normally.
//  rst_n low for 1 cycle mid-CALC -> busy/done/result=0 at once.
//   Back-to-back starts (start re-asserted the cycle after done) give two correct done pulses.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Holds the pipeline via stall while an op is in flight and pulses done with the result.
module mdu_sequencer #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  state_t              w_next_state;
  logic                w_accept;

  logic [2:0]          r_func3;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_opb;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_result;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic                r_busy;
  logic                r_done;

  logic                w_is_div;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_val;

  logic [XLEN:0]       w_mul_sum;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN:0]       w_div_diff;
  logic                w_div_ge;

  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quo_fix;
  logic [XLEN-1:0]     w_rem_fix;
  logic [XLEN-1:0]     w_fix_val;

  // Operand decode on the accept cycle; MUL runs unsigned since its low half is sign-agnostic.
  assign w_is_div   = func3[2];
  assign w_a_signed = (func3 == 3'b001) || (func3 == 3'b010) ||
                      (func3 == 3'b100) || (func3 == 3'b110);
  assign w_b_signed = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
  assign w_a_neg    = w_a_signed & rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1 : rs1;
  assign w_b_mag    = w_b_neg ? -rs2 : rs2;

  assign w_div_zero = w_is_div && (rs2 == '0);
  assign w_div_ovf  = w_is_div && !func3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
  assign w_special  = w_div_zero | w_div_ovf;

  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = func3[1] ? rs1 : '1;
    end else if (w_div_ovf) begin
      w_special_val = func3[1] ? '0 : rs1;
    end
  end

  // One multiply step: conditionally add into the high half, then shift the whole product right.
  assign w_mul_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opb} : '0);

  // One restoring-divide step; the remainder stays below the divisor, so bit XLEN of the difference is its sign.
  assign w_div_shift = {r_rem, r_quo[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};
  assign w_div_ge    = ~w_div_diff[XLEN];

  assign w_prod_fix  = r_neg_res ? -r_prod : r_prod;
  assign w_quo_fix   = r_neg_res ? -r_quo : r_quo;
  assign w_rem_fix   = r_neg_rem ? -r_rem : r_rem;

  always_comb begin
    w_fix_val = '0;
    case (r_func3)
      3'b000:                 w_fix_val = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_val = w_quo_fix;
      default:                w_fix_val = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_accept     = 1'b1;
          w_next_state = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX:   w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
    if (flush) begin
      w_next_state = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func3   <= '0;
      r_prod    <= '0;
      r_opb     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_next_state == S_CALC) || (w_next_state == S_FIX);
      r_done <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func3 <= func3;
            if (w_special) begin
              r_result <= w_special_val;
            end else begin
              r_prod    <= {{XLEN{1'b0}}, w_a_mag};
              r_opb     <= w_b_mag;
              r_rem     <= '0;
              r_quo     <= w_a_mag;
              r_cnt     <= CNT_W'(XLEN);
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
            end
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_func3[2]) begin
            r_rem <= w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_div_ge};
          end else begin
            r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_result <= w_fix_val;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall  = start & ~r_done & ~flush;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

`ifndef SYNTHESIS
  a_start_held: assert property (@(posedge clk) disable iff (!rst_n) r_busy |-> (start || flush))
    else $error("mdu_sequencer: start dropped while busy without flush");
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table for results/latency, plus flush, reset
// and done-cycle handshake sequences.
module tb_mdu_sequencer;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .func3  (func3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts one op on the next negedge, checks stall/busy every cycle up to done,
  // then the result and the accept-to-done latency. Returns at the done-cycle negedge.
  task automatic run_op(input vec_t v, input bit hold_start);
    bit ctl_ok;
    int cyc;
    int lat;
    @(negedge clk);
    func3 = v.f3;
    rs1   = v.a;
    rs2   = v.b;
    start = 1'b1;
    #1;
    ctl_ok = (stall === 1'b1);
    cyc = 0;
    lat = -1;
    while (cyc < 100 && lat < 0) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        lat = cyc;
      end else if (stall !== 1'b1 || busy !== 1'b1) begin
        ctl_ok = 1'b0;
      end
    end
    if (lat >= 0 && (stall !== 1'b0 || busy !== 1'b0)) ctl_ok = 1'b0;
    $display("[TB] %s f3=%0d rs1=%08h rs2=%08h -> result=%08h lat=%0d", v.name, v.f3, v.a, v.b,
             result, lat);
    check($sformatf("%s.result", v.name), result, v.exp);
    check($sformatf("%s.latency", v.name), 32'(lat), 32'(v.lat));
    check($sformatf("%s.stall_busy", v.name), {31'd0, ctl_ok}, 32'd1);
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    bit saw_done;
    vec_t v;

    vecs[0]  = '{"MUL_7xm3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{"MULH_minxmin",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{"MULHU_maxxmax",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{"MULHSU_m1x2",     3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{"DIV_m7d2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{"REM_m7d2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{"DIVU_100d7",      3'b101, 32'd100,       32'd7,         32'd14,        34};
    vecs[7]  = '{"REMU_100d7",      3'b111, 32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{"DIVU_5d0",        3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{"REM_5d0",         3'b110, 32'd5,         32'd0,         32'd5,         1};
    vecs[10] = '{"DIV_ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{"REM_ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{"MULH_m1xm1",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[13] = '{"DIV_7dm2",        3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[14] = '{"REM_7dm2",        3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
    vecs[15] = '{"DIV_m7dm2",       3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         34};
    vecs[16] = '{"REM_m7dm2",       3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34};
    vecs[17] = '{"DIVU_big_d2",     3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34};
    vecs[18] = '{"REMU_big_d2",     3'b111, 32'hFFFF_FFF9, 32'd2,         32'd1,         34};
    vecs[19] = '{"MULHSU_2xmax",    3'b010, 32'd2,         32'hFFFF_FFFF, 32'd1,         34};
    vecs[20] = '{"DIV_min_d1",      3'b100, 32'h8000_0000, 32'd1,         32'h8000_0000, 34};
    vecs[21] = '{"DIVU_min_dmax",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34};
    vecs[22] = '{"DIV_0d0",         3'b100, 32'd0,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[23] = '{"REMU_9d0",        3'b111, 32'd9,         32'd0,         32'd9,         1};

    repeat (2) @(negedge clk);
    check("reset.busy",   {31'd0, busy},  32'd0);
    check("reset.done",   {31'd0, done},  32'd0);
    check("reset.result", result,         32'd0);
    check("reset.stall",  {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // start still high through the done cycle must not restart the finished op
    v = '{"DIVU_hold", 3'b101, 32'd100, 32'd7, 32'd14, 34};
    run_op(v, 1'b1);
    @(negedge clk);
    check("hold.no_reaccept_busy", {31'd0, busy}, 32'd0);
    check("hold.no_reaccept_done", {31'd0, done}, 32'd0);
    start = 1'b0;

    // flush on the 10th CALC cycle
    v = '{"MULHU_prior", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, 34};
    run_op(v, 1'b0);
    @(negedge clk);
    func3 = 3'b000; rs1 = 32'd7; rs2 = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    check("flush.busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush.stall_low", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check("flush.busy_after", {31'd0, busy}, 32'd0);
    check("flush.result_kept", result, 32'd1);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    $display("[TB] flush mid-CALC: done seen=%0d result=%08h", saw_done, result);
    check("flush.no_done", {31'd0, saw_done}, 32'd0);
    v = '{"MUL_after_flush", 3'b000, 32'd7, 32'd3, 32'd21, 34};
    run_op(v, 1'b0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    func3 = 3'b001; rs1 = 32'h1234_5678; rs2 = 32'h0000_0010; start = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    $display("[TB] reset mid-CALC: busy=%0d done=%0d result=%08h", busy, done, result);
    check("rst_mid.busy",   {31'd0, busy}, 32'd0);
    check("rst_mid.done",   {31'd0, done}, 32'd0);
    check("rst_mid.result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back: second start one cycle after the first done
    v = '{"B2B_DIV", 3'b100, 32'hFFFF_FF9C, 32'd10, 32'hFFFF_FFF6, 34};
    run_op(v, 1'b0);
    v = '{"B2B_MULHU", 3'b011, 32'h8000_0000, 32'd4, 32'd2, 34};
    run_op(v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
